bcd_timer: RTL and testbench

- Sits downstream of the keypad BCD encoder and accepts its digit D[3:0] and load strobe loadn (active-low).
- Each valid key press shifts one digit into a 4-digit MM:SS BCD register.
- While the magnetron enable is high, the register counts down once per prescaled tick.
- Flags zero and pulses done for the magnetron control FSM and the display.

---
 rtl/bcd_timer.sv | 174 +++++++++++++++++
 tb/tb_bcd_timer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer.sv
// ---------------------------------------------------------------------------
// bcd_timer
//
// Four-digit MM:SS BCD countdown timer for the magnetron controller.
// Digits are entered one key at a time from the keypad BCD encoder. Each
// accepted key shifts the register left by one digit. While the magnetron
// enable is high, the register counts down by one second per prescaled tick.
//
// Ports
//   clk       in   system clock, rising-edge active
//   clearn    in   asynchronous active-low reset, doubles as the "clear" key
//   D[3:0]    in   BCD digit from the keypad encoder
//   loadn     in   active-low level: digit on D is valid
//   en        in   1 = magnetron on: countdown runs and key loads are blocked
//   sec_ones  out  BCD seconds units
//   sec_tens  out  BCD seconds tens
//   min_ones  out  BCD minutes units
//   min_tens  out  BCD minutes tens
//   zero      out  all four digits are 0 (combinational from the digit regs)
//   done      out  one-cycle pulse after a countdown step lands on 00:00
//
// Parameters
//   TICK_DIV       clk cycles per countdown step (>= 2)
//   SEC_TENS_WRAP  value loaded into the seconds-tens digit on a borrow
// ---------------------------------------------------------------------------
module bcd_timer #(
    parameter int TICK_DIV      = 100,
    parameter int SEC_TENS_WRAP = 5
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       zero,
    output logic       done
);

    // Prescaler width: enough bits to hold TICK_DIV-1.
    localparam int          PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]  TENS_WRAP = 4'(SEC_TENS_WRAP);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [3:0]    sec_ones_q, sec_ones_d;
    logic [3:0]    sec_tens_q, sec_tens_d;
    logic [3:0]    min_ones_q, min_ones_d;
    logic [3:0]    min_tens_q, min_tens_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic          loadn_q;
    logic          done_q,     done_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic       zero_w;
    logic       load_evt;
    logic       run;
    logic       tick;
    logic [3:0] dec_sec_ones;
    logic [3:0] dec_sec_tens;
    logic [3:0] dec_min_ones;
    logic [3:0] dec_min_tens;
    logic       dec_is_zero;

    assign zero_w = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                    (min_ones_q == 4'd0) && (min_tens_q == 4'd0);

    // Falling edge of loadn, only with the magnetron off and a legal BCD
    // digit. Edges seen while en=1 or with D>9 are simply lost, not queued.
    assign load_evt = loadn_q && !loadn && !en && (D <= 4'd9);

    // The prescaler only advances while there is something to count down.
    assign run  = en && !zero_w;
    assign tick = run && (presc_q == PRE_LAST);

    // BCD ripple-borrow decrement of the whole register. Only used when
    // zero_w is low, so the minutes-tens digit is never 0 when it is
    // borrowed from. Non-canonical seconds (e.g. 99) are decremented as-is.
    always_comb begin
        dec_sec_ones = sec_ones_q;
        dec_sec_tens = sec_tens_q;
        dec_min_ones = min_ones_q;
        dec_min_tens = min_tens_q;
        if (sec_ones_q != 4'd0) begin
            dec_sec_ones = sec_ones_q - 4'd1;
        end else begin
            dec_sec_ones = 4'd9;
            if (sec_tens_q != 4'd0) begin
                dec_sec_tens = sec_tens_q - 4'd1;
            end else begin
                dec_sec_tens = TENS_WRAP;
                if (min_ones_q != 4'd0) begin
                    dec_min_ones = min_ones_q - 4'd1;
                end else begin
                    dec_min_ones = 4'd9;
                    dec_min_tens = min_tens_q - 4'd1;
                end
            end
        end
    end

    assign dec_is_zero = (dec_sec_ones == 4'd0) && (dec_sec_tens == 4'd0) &&
                         (dec_min_ones == 4'd0) && (dec_min_tens == 4'd0);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        presc_d    = '0;
        done_d     = 1'b0;

        // load_evt needs en=0 and tick needs en=1, so they never coincide.
        if (load_evt) begin
            min_tens_d = min_ones_q;
            min_ones_d = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = D;
        end else if (tick) begin
            sec_ones_d = dec_sec_ones;
            sec_tens_d = dec_sec_tens;
            min_ones_d = dec_min_ones;
            min_tens_d = dec_min_tens;
            done_d     = dec_is_zero;
        end

        // Cleared whenever the countdown is paused or idle, so each resume
        // starts a full period.
        if (run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            presc_q    <= '0;
            loadn_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            presc_q    <= presc_d;
            loadn_q    <= loadn;
            done_q     <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign min_ones = min_ones_q;
    assign min_tens = min_tens_q;
    assign zero     = zero_w;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_timer
//
// Directed and randomized stimulus for bcd_timer. The reference model keeps
// the time as a plain decimal number MMSS (0..9999): a key press is
// "shift in one decimal digit", a countdown step is "one second less" with
// minutes/seconds arithmetic, where seconds 00 wrap to 59.
// ---------------------------------------------------------------------------
module tb_bcd_timer;

  localparam int TD   = 4;
  localparam int WRAP = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clearn;
  logic [3:0] d_in;
  logic       loadn;
  logic       en;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       zero, done;

  always #5 clk = ~clk;

  bcd_timer #(.TICK_DIV(TD), .SEC_TENS_WRAP(WRAP)) dut (
    .clk      (clk),
    .clearn   (clearn),
    .D        (d_in),
    .loadn    (loadn),
    .en       (en),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .zero     (zero),
    .done     (done)
  );

  // ---------------- reference model ----------------
  int m_val;       // MMSS as a decimal integer
  int m_run_cnt;   // enabled, non-zero cycles since last step/pause
  bit m_prev_ln;   // loadn seen on the previous clock
  bit m_done;

  int checks = 0;
  int errors = 0;

  function automatic int one_second_less(int v);
    int mm, ss;
    mm = v / 100;
    ss = v % 100;
    if (ss > 0) ss = ss - 1;
    else begin
      ss = WRAP * 10 + 9;
      mm = mm - 1;
    end
    return mm * 100 + ss;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_val     = 0;
    m_run_cnt = 0;
    m_prev_ln = 1'b1;
    m_done    = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_digits"}, {min_tens, min_ones, sec_tens, sec_ones}, to_bcd(m_val));
    check({tag, "_zero"}, {15'd0, zero}, {15'd0, (m_val == 0)});
    check({tag, "_done"}, {15'd0, done}, {15'd0, m_done});
  endtask

  // ---------------- driver ----------------
  // Drive inputs for one clock, advance the model, sample 1 time unit after
  // the edge.
  task automatic step(input logic [3:0] d, input logic ln, input logic e, input string tag);
    bit is_zero, press, stepped;
    d_in  = d;
    loadn = ln;
    en    = e;
    is_zero = (m_val == 0);
    press   = m_prev_ln && !ln && !e && (d <= 4'd9);
    stepped = e && !is_zero && (m_run_cnt == TD - 1);
    m_done  = 1'b0;
    if (press) m_val = (m_val * 10 + int'(d)) % 10000;
    else if (stepped) begin
      m_val  = one_second_less(m_val);
      m_done = (m_val == 0);
    end
    if (e && !is_zero) m_run_cnt = stepped ? 0 : m_run_cnt + 1;
    else m_run_cnt = 0;
    m_prev_ln = ln;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic press_key(input logic [3:0] d, input int low_cyc, input int high_cyc);
    for (int i = 0; i < low_cyc; i++) step(d, 1'b0, 1'b0, "press_low");
    for (int i = 0; i < high_cyc; i++) step(d, 1'b1, 1'b0, "press_high");
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] e);
    step(4'd0, 1'b1, 1'b0, "pre_load");
    press_key(a, 3, 2);
    press_key(b, 3, 2);
    press_key(c, 3, 2);
    press_key(e, 3, 2);
  endtask

  task automatic run_en(input int n, input logic e, input string tag);
    for (int i = 0; i < n; i++) step(4'd0, 1'b1, e, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic r_ln, r_en;
    clearn = 1'b0;
    d_in   = 4'd0;
    loadn  = 1'b1;
    en     = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    check("reset_zero_const", {15'd0, zero}, 16'd1);
    @(posedge clk); #1;
    clearn = 1'b1;

    // Load sequence: 1,2,3,0 -> 12:30
    load4(4'd1, 4'd2, 4'd3, 4'd0);
    check("load_1230", {min_tens, min_ones, sec_tens, sec_ones}, 16'h1230);
    // Held-low press of 7 for 10 cycles: one shift only
    press_key(4'd7, 10, 2);
    check("held_2307", {min_tens, min_ones, sec_tens, sec_ones}, 16'h2307);

    // Invalid digit with en=0
    step(4'hA, 1'b0, 1'b0, "bad_digit");
    step(4'hA, 1'b1, 1'b0, "bad_digit_rel");
    check("bad_digit_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h2307);
    // Legal digit but en=1: ignored and not deferred
    step(4'd5, 1'b0, 1'b1, "en_block");
    step(4'd5, 1'b0, 1'b0, "en_block_low");
    step(4'd5, 1'b1, 1'b0, "en_block_rel");
    check("en_block_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h2307);

    // Countdown borrow 01:00 -> 00:59 -> 00:58
    load4(4'd0, 4'd1, 4'd0, 4'd0);
    check("load_0100", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0100);
    run_en(3, 1'b1, "cd_wait");
    check("cd_not_yet", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0100);
    run_en(1, 1'b1, "cd_step1");
    check("cd_0059", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
    run_en(4, 1'b1, "cd_step2");
    check("cd_0058", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0058);
    run_en(1, 1'b0, "cd_stop");

    // 10:00 -> 09:59
    load4(4'd1, 4'd0, 4'd0, 4'd0);
    run_en(4, 1'b1, "cd10");
    check("cd_0959", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0959);
    run_en(1, 1'b0, "cd10_stop");

    // Completion: 00:02 -> 00:01 -> 00:00 with one done pulse
    load4(4'd0, 4'd0, 4'd0, 4'd2);
    run_en(4, 1'b1, "fin1");
    check("fin_0001", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0001);
    run_en(4, 1'b1, "fin2");
    check("fin_done_hi", {15'd0, done}, 16'd1);
    check("fin_0000", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    run_en(1, 1'b1, "fin3");
    check("fin_done_lo", {15'd0, done}, 16'd0);
    run_en(20, 1'b1, "idle_hold");
    check("idle_0000", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    run_en(1, 1'b0, "idle_stop");

    // Loading 0000 must not pulse done
    load4(4'd0, 4'd0, 4'd0, 4'd0);
    check("load0_no_done", {15'd0, done}, 16'd0);

    // Pause / resume
    load4(4'd0, 4'd0, 4'd0, 4'd5);
    run_en(6, 1'b1, "pause_run");
    check("pause_0004", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0004);
    run_en(10, 1'b0, "paused");
    check("paused_0004", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0004);
    run_en(3, 1'b1, "resume_wait");
    check("resume_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0004);
    run_en(1, 1'b1, "resume_step");
    check("resume_0003", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0003);
    run_en(1, 1'b0, "resume_stop");

    // Non-canonical seconds: 00:99 counts down as-is
    load4(4'd0, 4'd0, 4'd9, 4'd9);
    run_en(8, 1'b1, "noncanon");
    check("noncanon_0097", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0097);
    run_en(1, 1'b0, "noncanon_stop");

    // Randomized phase
    r_en = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) r_en = ~r_en;
      r_ln = ($urandom_range(0, 2) != 0);
      step(4'($urandom_range(0, 15)), r_ln, r_en, "rand");
    end

    // Asynchronous reset mid-count with 12:34
    load4(4'd1, 4'd2, 4'd3, 4'd4);
    run_en(2, 1'b1, "pre_reset");
    #2;
    clearn = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    @(posedge clk); #1;
    check_all("reset_held");
    clearn = 1'b1;
    en     = 1'b0;
    loadn  = 1'b1;
    load4(4'd4, 4'd3, 4'd2, 4'd1);
    check("post_reset_load", {min_tens, min_ones, sec_tens, sec_ones}, 16'h4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
